sp_pack_ctrl: RTL
=================

Name: sp_pack_ctrl

Overview:
Stream packer controller that sequences an enabled serial-to-parallel shift register. It accepts N-bit beats on a valid/ready input and counts M beats per word. Each completed MN-bit word moves into a holding register and is presented on a valid/ready output. Sits between a narrow producer (e.g. nibble decoder, UART byte stream) and a wide consumer, and gives the shift register backpressure it does not have on its own.

Parameters:
N, 4, bits per input beat (N >= 1)
M, 2, beats per output word (M >= 2); output width M*N

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high; clears all state
in_valid  input  1  producer has a beat on in_data
in_data  input  N  beat payload
in_ready  output  1  block accepts beat this cycle (accept = in_valid & in_ready)
out_valid  output  1  out_data holds a complete word
out_data  output  M*N  packed word; first-accepted beat in bits [M*N-1 -: N]
out_ready  input  1  consumer takes word this cycle (take = out_valid & out_ready)
busy  output  1  beat_cnt != 0 (partial word in progress)

Behaviour:
- Reset (asynchronous, active-high; clock clk): beat_cnt=0, shift register=0, out_data=0, out_valid=0, in_ready=1, busy=0.
- Internal shift register sr[M*N-1:0]. Shift enable = accept. On accept, sr <= {sr[M*N-N-1:0], in_data} (new beat enters the LSBs, older beats move up).
- beat_cnt, width $clog2(M): increments on accept. On the accept with beat_cnt==M-1 it wraps to 0.
- Completing accept (beat_cnt==M-1): out_data <= {sr[(M-1)*N-1:0], in_data}; out_valid <= 1 on the next edge. Latency: word is visible the cycle after the last beat is accepted.
- in_ready = (beat_cnt != M-1) | ~out_valid | out_ready.
  - Beats 0..M-2 are always accepted, even while a word is held.
  - The last beat stalls only while the holding register is occupied and not being drained.
  - in_ready is combinational from out_ready; there is no path from in_valid to in_ready.
- out_valid clears on take unless a completing accept occurs in the same cycle. In that case out_valid stays 1 and out_data loads the new word, giving full throughput of one word per M cycles.
- out_data is stable while out_valid=1 and out_ready=0. in_valid and in_data must also hold until accepted (AXI-style rules).
- Outside these events sr, out_data and beat_cnt hold.
- Reset mid-word or mid-hold discards the partial word and any held word immediately, with no output pulse.

Optional Feature:
Macro SP_PACK_FLUSH_EN.
- Defined: adds port flush (input, 1) and out_count (output, $clog2(M+1)).
  - A flush pulse sets flush_pend.
  - flush_pend executes on the first cycle with beat_cnt==k>0, no completing accept, and a free slot (~out_valid | out_ready).
  - On execute: out_data <= sr[k*N-1:0] << ((M-k)*N), zero-padding the LSBs; out_count <= k; out_valid <= 1; beat_cnt <= 0; flush_pend clears.
  - A beat accepted in the execute cycle is included, with k counted after that beat.
  - flush_pend clears without output when beat_cnt==0 and there is no accept.
  - Full words report out_count=M. Reset clears flush_pend and out_count.
- Undefined: no flush or out_count ports; partial words stay in sr until completed or reset.

Test Plan:
1. N=4,M=2: accept 0xA then 0xB, out_ready=1 → out_valid=1 for one cycle with out_data=0xAB, the cycle after 0xB is accepted; busy 1 then 0.
2. Backpressure: out_ready=0 and word 0xAB held; send 0xC then 0xD → 0xC accepted, in_ready=0 on 0xD, out_data stays 0xAB. Raise out_ready → 0xAB taken, 0xD accepted in the same cycle, next cycle out_data=0xCD.
3. Continuous in_valid with out_ready=1 and beats 1,2,3,4,5,6 → words 0x12, 0x34, 0x56 on consecutive 2-cycle boundaries, in_ready never drops.
4. Reset asserted asynchronously mid-clock after 0xE accepted with 0x12 held → out_valid, busy and out_data go to 0 immediately; next beats 0x3, 0x4 produce 0x34 (0xE lost).
5. SP_PACK_FLUSH_EN, N=4,M=3: accept 0x7, pulse flush → out_data=0x700, out_count=1. Flush with beat_cnt=0 → no output. Flush while holding a word with out_ready=0 → executes after the take.
6. M=4,N=8 parametrised run: random valid/ready, 1000 beats → a scoreboard of concatenated beats matches the out_data sequence exactly.

Source files
------------

// File: rtl/sp_pack_ctrl.sv
// sp_pack_ctrl: stream packer, M beats of N bits into one M*N-bit word.
// Adds valid/ready flow control and a one-word holding register.
//
// Ports:
//   clk, reset       rising-edge clock, async active-high reset
//   in_valid/ready   beat handshake, payload in_data[N-1:0]
//   out_valid/ready  word handshake, payload out_data[M*N-1:0]
//                    (first accepted beat in the MSBs)
//   busy             a partial word is in progress
//   flush, out_count only with SP_PACK_FLUSH_EN defined: emit a
//                    partial word, left aligned, out_count = beats
module sp_pack_ctrl #(
    parameter int N = 4,
    parameter int M = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [N-1:0]           in_data,
    output logic                   in_ready,
    output logic                   out_valid,
    output logic [M*N-1:0]         out_data,
    input  logic                   out_ready,
`ifdef SP_PACK_FLUSH_EN
    input  logic                   flush,
    output logic [$clog2(M+1)-1:0] out_count,
`endif
    output logic                   busy
);

    localparam int W  = M * N;
    localparam int CW = $clog2(M);
    localparam logic [CW-1:0] LAST = CW'(M - 1);

    logic [CW-1:0] beat_cnt;
    logic [W-1:0]  sr;
    logic [W-1:0]  sr_nxt;
    logic          last;
    logic          accept;
    logic          complete;
    logic          take;

    assign last     = (beat_cnt == LAST);
    // Only the word-completing beat needs a free holding slot.
    assign in_ready = ~last | ~out_valid | out_ready;
    assign accept   = in_valid & in_ready;
    assign complete = accept & last;
    assign take     = out_valid & out_ready;
    assign sr_nxt   = {sr[W-N-1:0], in_data};
    assign busy     = (beat_cnt != '0);

`ifdef SP_PACK_FLUSH_EN
    localparam int OW = $clog2(M + 1);
    localparam logic [OW-1:0] FULL = OW'(M);

    logic          flush_pend;
    logic [OW-1:0] k;
    logic          fl_exec;
    logic          fl_drop;
    logic [W-1:0]  fl_src;
    logic [W-1:0]  fl_word;

    // Beat count including a beat accepted in this cycle.
    assign k       = OW'(beat_cnt) + OW'(accept);
    assign fl_exec = flush_pend & ~complete & (k != '0) &
                     (~out_valid | out_ready);
    assign fl_drop = flush_pend & ~accept & (beat_cnt == '0);
    assign fl_src  = accept ? sr_nxt : sr;
    // Left shift drops stale bits above the k live beats.
    assign fl_word = fl_src << ((M - int'(k)) * N);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beat_cnt   <= '0;
            sr         <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
`ifdef SP_PACK_FLUSH_EN
            flush_pend <= 1'b0;
            out_count  <= '0;
`endif
        end else begin
            if (accept) begin
                sr <= sr_nxt;
            end

            if (complete) begin
                beat_cnt <= '0;
            end else if (accept) begin
                beat_cnt <= beat_cnt + 1'b1;
            end

            if (complete) begin
                out_data  <= sr_nxt;
                out_valid <= 1'b1;
`ifdef SP_PACK_FLUSH_EN
                out_count <= FULL;
`endif
            end
`ifdef SP_PACK_FLUSH_EN
            else if (fl_exec) begin
                out_data  <= fl_word;
                out_valid <= 1'b1;
                out_count <= k;
                beat_cnt  <= '0;
            end
`endif
            else if (take) begin
                out_valid <= 1'b0;
            end

`ifdef SP_PACK_FLUSH_EN
            flush_pend <= flush |
                          (flush_pend & ~fl_exec & ~fl_drop);
`endif
        end
    end

endmodule
